// File: rtl/exec_control_core_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : exec_control_core_pkg                                        |
// | Purpose  : Shared types and opcode constants for the execute/control    |
// |            core (ALU modes, write-back source, PC source, control set). |
// | Revision : 1.0  initial release                                         |
// ---------------------------------------------------------------------------
package exec_control_core_pkg;

  // ALU operation codes; value equals {funct7[5], funct3} for R-type ops
  typedef enum logic [3:0] {
    ALU_ADD    = 4'b0000,
    ALU_SLL    = 4'b0001,
    ALU_SLT    = 4'b0010,
    ALU_SLTU   = 4'b0011,
    ALU_XOR    = 4'b0100,
    ALU_SRL    = 4'b0101,
    ALU_OR     = 4'b0110,
    ALU_AND    = 4'b0111,
    ALU_SUB    = 4'b1000,
    ALU_SRA    = 4'b1101,
    ALU_PASS_B = 4'b1111
  } alu_mode_t;

  typedef enum logic [1:0] {
    DEST_REG_FROM_NONE    = 2'd0,
    DEST_REG_FROM_ALU     = 2'd1,
    DEST_REG_FROM_BUS     = 2'd2,
    DEST_REG_FROM_NEXT_PC = 2'd3
  } dest_reg_from_t;

  typedef enum logic [0:0] {
    PC_SRC_STEP = 1'b0,
    PC_SRC_ALU  = 1'b1
  } pc_src_t;

  typedef enum logic [0:0] {
    ST_FETCH   = 1'b0,
    ST_EXECUTE = 1'b1
  } ctrl_state_t;

  typedef struct packed {
    logic           sel_alu_a;
    logic           sel_alu_b;
    dest_reg_from_t dest_reg_from;
    pc_src_t        pc_src;
    logic           en_comp_unit;
    logic           dbus_re;
    logic           dbus_we;
  } ins_ctrl_signals_t;

  localparam logic [6:0] c_OPC_LUI      = 7'b0110111;
  localparam logic [6:0] c_OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] c_OPC_JAL      = 7'b1101111;
  localparam logic [6:0] c_OPC_JALR     = 7'b1100111;
  localparam logic [6:0] c_OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] c_OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] c_OPC_STORE    = 7'b0100011;
  localparam logic [6:0] c_OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] c_OPC_OP       = 7'b0110011;
  localparam logic [6:0] c_OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] c_OPC_SYSTEM   = 7'b1110011;

  // Build an ALU mode from the instruction's funct7[5] and funct3 bits
  function automatic logic [3:0] f_alu_mode(input logic i_f7b5, input logic [2:0] i_f3);
    return {i_f7b5, i_f3};
  endfunction

endpackage
`default_nettype wire

// File: rtl/exec_control_core_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : exec_control_core_if                                         |
// | Purpose  : Bundle between the CPU top level (master) and the execute/   |
// |            control core (slave): instruction fields, operands, results  |
// |            and datapath control.                                        |
// | Revision : 1.0  initial release                                         |
// ---------------------------------------------------------------------------
interface exec_control_core_if #(
  parameter int XLEN = 32
);
  logic            stall;
  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [XLEN-1:0] alu_in_a;
  logic [XLEN-1:0] alu_in_b;
  logic [XLEN-1:0] cmp_a;
  logic [XLEN-1:0] cmp_b;

  logic [XLEN-1:0] alu_out;
  logic            cmp_result;
  logic [3:0]      alu_mode;
  logic            sel_alu_a;
  logic            sel_alu_b;
  logic [1:0]      dest_reg_from;
  logic            pc_src;
  logic            en_comp_unit;
  logic            dbus_re;
  logic            dbus_we;
  logic            load_ir;
  logic            en_iaddr;
  logic            en_pc_counter;

  modport master (
    output stall, opcode, f3, f7, alu_in_a, alu_in_b, cmp_a, cmp_b,
    input  alu_out, cmp_result, alu_mode, sel_alu_a, sel_alu_b, dest_reg_from,
           pc_src, en_comp_unit, dbus_re, dbus_we, load_ir, en_iaddr, en_pc_counter
  );

  modport slave (
    input  stall, opcode, f3, f7, alu_in_a, alu_in_b, cmp_a, cmp_b,
    output alu_out, cmp_result, alu_mode, sel_alu_a, sel_alu_b, dest_reg_from,
           pc_src, en_comp_unit, dbus_re, dbus_we, load_ir, en_iaddr, en_pc_counter
  );
endinterface
`default_nettype wire

// File: rtl/exec_control_core_alu.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : exec_alu                                                     |
// | Purpose  : Combinational RV32I ALU. Wrapping arithmetic, 5-bit shift    |
// |            amount, sign-filling SRA; unassigned modes yield zero.       |
// | Revision : 1.0  initial release                                         |
// ---------------------------------------------------------------------------
module exec_alu
  import exec_control_core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  wire logic [3:0]      i_mode,
  input  wire logic [XLEN-1:0] i_a,
  input  wire logic [XLEN-1:0] i_b,
  output logic      [XLEN-1:0] o_result
);

  logic [4:0] w_shamt;
  assign w_shamt = i_b[4:0];

  // Select the result of the requested operation
  always_comb begin
    o_result = '0;
    case (i_mode)
      ALU_ADD:    o_result = i_a + i_b;
      ALU_SUB:    o_result = i_a - i_b;
      ALU_SLL:    o_result = i_a << w_shamt;
      ALU_SLT:    o_result = {{(XLEN-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      ALU_SLTU:   o_result = {{(XLEN-1){1'b0}}, (i_a < i_b)};
      ALU_XOR:    o_result = i_a ^ i_b;
      ALU_SRL:    o_result = i_a >> w_shamt;
      ALU_SRA:    o_result = $unsigned($signed(i_a) >>> w_shamt);
      ALU_OR:     o_result = i_a | i_b;
      ALU_AND:    o_result = i_a & i_b;
      ALU_PASS_B: o_result = i_b;
      default:    o_result = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/exec_control_core.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : exec_control_core                                            |
// | Purpose  : Execute-stage ALU, branch comparator, fetch/execute FSM and  |
// |            instruction decoder for the multi-cycle RV32I core.          |
// | Revision : 1.0  initial release                                         |
// ---------------------------------------------------------------------------
module exec_control_core
  import exec_control_core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input wire logic           clk,
  input wire logic           rst,   // asynchronous, active low
  exec_control_core_if.slave bus
);

  ctrl_state_t       r_state;
  ctrl_state_t       w_state_next;
  ins_ctrl_signals_t w_ctrl;
  logic [3:0]        w_alu_mode;
  logic [XLEN-1:0]   w_alu_out;
  logic              w_cmp;
  logic              w_en_iaddr;
  logic              w_load_ir;
  logic              w_en_pc_counter;

  // Only funct7[5] matters to RV32I decode; the remaining bits are ignored
  logic w_unused_f7;
  assign w_unused_f7 = ^{bus.f7[6], bus.f7[4:0]};

  exec_alu #(.XLEN(XLEN)) u_alu (
    .i_mode   (w_alu_mode),
    .i_a      (bus.alu_in_a),
    .i_b      (bus.alu_in_b),
    .o_result (w_alu_out)
  );

  // Branch condition evaluation from funct3
  always_comb begin
    w_cmp = 1'b0;
    case (bus.f3)
      3'b000:  w_cmp = (bus.cmp_a == bus.cmp_b);
      3'b001:  w_cmp = (bus.cmp_a != bus.cmp_b);
      3'b100:  w_cmp = ($signed(bus.cmp_a) <  $signed(bus.cmp_b));
      3'b101:  w_cmp = ($signed(bus.cmp_a) >= $signed(bus.cmp_b));
      3'b110:  w_cmp = (bus.cmp_a <  bus.cmp_b);
      3'b111:  w_cmp = (bus.cmp_a >= bus.cmp_b);
      default: w_cmp = 1'b0;
    endcase
  end

  // State register; reset aborts any instruction and restarts with a fetch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_FETCH;
    else      r_state <= w_state_next;
  end

  // Next-state and sequencing strobes; stall freezes the current state
  always_comb begin
    w_state_next    = r_state;
    w_en_iaddr      = 1'b0;
    w_load_ir       = 1'b0;
    w_en_pc_counter = 1'b0;
    case (r_state)
      ST_FETCH: begin
        w_en_iaddr = 1'b1;
        w_load_ir  = 1'b1;
        if (!bus.stall) w_state_next = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        w_en_pc_counter = 1'b1;
        if (!bus.stall) w_state_next = ST_FETCH;
      end
      default: w_state_next = ST_FETCH;
    endcase
  end

  // Instruction decode; controls stay inactive outside EXECUTE
  always_comb begin
    w_ctrl     = '0;
    w_alu_mode = ALU_ADD;
    if (r_state == ST_EXECUTE) begin
      case (bus.opcode)
        c_OPC_LUI: begin
          w_ctrl.sel_alu_b     = 1'b1;
          w_alu_mode           = ALU_PASS_B;
          w_ctrl.dest_reg_from = DEST_REG_FROM_ALU;
        end
        c_OPC_AUIPC: begin
          w_ctrl.sel_alu_a     = 1'b1;
          w_ctrl.sel_alu_b     = 1'b1;
          w_ctrl.dest_reg_from = DEST_REG_FROM_ALU;
        end
        c_OPC_JAL: begin
          w_ctrl.sel_alu_a     = 1'b1;
          w_ctrl.sel_alu_b     = 1'b1;
          w_ctrl.pc_src        = PC_SRC_ALU;
          w_ctrl.dest_reg_from = DEST_REG_FROM_NEXT_PC;
        end
        c_OPC_JALR: begin
          // Target bit 0 is cleared downstream in the PC block
          w_ctrl.sel_alu_b     = 1'b1;
          w_ctrl.pc_src        = PC_SRC_ALU;
          w_ctrl.dest_reg_from = DEST_REG_FROM_NEXT_PC;
        end
        c_OPC_BRANCH: begin
          w_ctrl.en_comp_unit = 1'b1;
        end
        c_OPC_LOAD: begin
          w_ctrl.sel_alu_b     = 1'b1;
          w_ctrl.dbus_re       = 1'b1;
          w_ctrl.dest_reg_from = DEST_REG_FROM_BUS;
        end
        c_OPC_STORE: begin
          w_ctrl.sel_alu_b = 1'b1;
          w_ctrl.dbus_we   = 1'b1;
        end
        c_OPC_OP_IMM: begin
          // funct7[5] of an I-type is immediate data, except for SRLI/SRAI
          w_ctrl.sel_alu_b     = 1'b1;
          w_ctrl.dest_reg_from = DEST_REG_FROM_ALU;
          if (bus.f3 == 3'b101) w_alu_mode = f_alu_mode(bus.f7[5], bus.f3);
          else                  w_alu_mode = f_alu_mode(1'b0, bus.f3);
        end
        c_OPC_OP: begin
          w_ctrl.dest_reg_from = DEST_REG_FROM_ALU;
          w_alu_mode           = f_alu_mode(bus.f7[5], bus.f3);
        end
        default: begin
          // MISC-MEM, SYSTEM and unknown opcodes execute as NOP
          w_ctrl     = '0;
          w_alu_mode = ALU_ADD;
        end
      endcase
    end
  end

  assign bus.alu_out       = w_alu_out;
  assign bus.cmp_result    = w_cmp;
  assign bus.alu_mode      = w_alu_mode;
  assign bus.sel_alu_a     = w_ctrl.sel_alu_a;
  assign bus.sel_alu_b     = w_ctrl.sel_alu_b;
  assign bus.dest_reg_from = w_ctrl.dest_reg_from;
  assign bus.pc_src        = w_ctrl.pc_src;
  assign bus.en_comp_unit  = w_ctrl.en_comp_unit;
  assign bus.dbus_re       = w_ctrl.dbus_re;
  assign bus.dbus_we       = w_ctrl.dbus_we;
  assign bus.load_ir       = w_load_ir;
  assign bus.en_iaddr      = w_en_iaddr;
  assign bus.en_pc_counter = w_en_pc_counter;

endmodule
`default_nettype wire

// File: tb/tb_exec_control_core.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : tb_exec_control_core                                         |
// | Purpose  : Directed self-checking bench for exec_control_core.          |
// | Revision : 1.0  initial release                                         |
// ---------------------------------------------------------------------------
module tb_exec_control_core;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  exec_control_core_if #(.XLEN(32)) u_if ();

  exec_control_core #(.XLEN(32)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  // {sel_alu_a, sel_alu_b, dest_reg_from[1:0], pc_src, en_comp_unit, dbus_re, dbus_we}
  wire [7:0] w_ctl = {u_if.sel_alu_a, u_if.sel_alu_b, u_if.dest_reg_from,
                      u_if.pc_src, u_if.en_comp_unit, u_if.dbus_re, u_if.dbus_we};
  // {en_iaddr, load_ir, en_pc_counter}
  wire [2:0] w_seq = {u_if.en_iaddr, u_if.load_ir, u_if.en_pc_counter};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_ins(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7);
    u_if.opcode = opc;
    u_if.f3     = f3;
    u_if.f7     = f7;
  endtask

  // Directed stimulus sequence
  initial begin
    n_checks = 0;
    n_errors = 0;
    rst            = 1'b0;
    u_if.stall     = 1'b1;
    u_if.opcode    = 7'b0110011;
    u_if.f3        = 3'b000;
    u_if.f7        = 7'b0000000;
    u_if.alu_in_a  = 32'h0;
    u_if.alu_in_b  = 32'h0;
    u_if.cmp_a     = 32'h0;
    u_if.cmp_b     = 32'h0;

    // Reset state: FETCH, no decoded controls
    repeat (2) @(posedge clk);
    #1;
    chk("reset_seq", {29'd0, w_seq}, 32'b110);
    chk("reset_ctl", {24'd0, w_ctl}, 32'h0);
    chk("reset_mode", {28'd0, u_if.alu_mode}, 32'h0);

    // Release reset with stall held: FETCH is kept
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("stall_fetch_%0d", i), {29'd0, w_seq}, 32'b110);
    end

    // Drop stall: EXECUTE, then back to FETCH, then EXECUTE again
    @(negedge clk);
    u_if.stall = 1'b0;
    @(posedge clk);
    #1;
    chk("exec_seq", {29'd0, w_seq}, 32'b001);
    @(posedge clk);
    #1;
    chk("back_fetch_seq", {29'd0, w_seq}, 32'b110);
    @(posedge clk);
    #1;
    chk("exec2_seq", {29'd0, w_seq}, 32'b001);
    @(negedge clk);
    u_if.stall = 1'b1;

    // ALU through OP decode while EXECUTE is held by stall
    set_ins(7'b0110011, 3'b000, 7'b0000000);
    u_if.alu_in_a = 32'h7FFF_FFFF; u_if.alu_in_b = 32'h1; #1;
    chk("alu_add_wrap", u_if.alu_out, 32'h8000_0000);
    chk("op_ctl", {24'd0, w_ctl}, 32'b0001_0000);
    set_ins(7'b0110011, 3'b000, 7'b0100000);
    u_if.alu_in_a = 32'h0; u_if.alu_in_b = 32'h1; #1;
    chk("op_sub_mode", {28'd0, u_if.alu_mode}, 32'b1000);
    chk("alu_sub_wrap", u_if.alu_out, 32'hFFFF_FFFF);
    set_ins(7'b0110011, 3'b101, 7'b0100000);
    u_if.alu_in_a = 32'h8000_0000; u_if.alu_in_b = 32'h4; #1;
    chk("alu_sra", u_if.alu_out, 32'hF800_0000);
    set_ins(7'b0110011, 3'b101, 7'b0000000); #1;
    chk("alu_srl", u_if.alu_out, 32'h0800_0000);
    u_if.alu_in_b = 32'h24; #1;
    chk("alu_srl_shamt5", u_if.alu_out, 32'h0800_0000);
    set_ins(7'b0110011, 3'b001, 7'b0000000);
    u_if.alu_in_a = 32'h0000_0001; u_if.alu_in_b = 32'h1F; #1;
    chk("alu_sll", u_if.alu_out, 32'h8000_0000);
    set_ins(7'b0110011, 3'b010, 7'b0000000);
    u_if.alu_in_a = 32'hFFFF_FFFF; u_if.alu_in_b = 32'h1; #1;
    chk("alu_slt", u_if.alu_out, 32'h1);
    set_ins(7'b0110011, 3'b011, 7'b0000000); #1;
    chk("alu_sltu", u_if.alu_out, 32'h0);
    set_ins(7'b0110011, 3'b100, 7'b0000000);
    u_if.alu_in_a = 32'hF0F0_00FF; u_if.alu_in_b = 32'h0FF0_0F0F; #1;
    chk("alu_xor", u_if.alu_out, 32'hFF00_0FF0);
    set_ins(7'b0110011, 3'b110, 7'b0000000); #1;
    chk("alu_or", u_if.alu_out, 32'hFFF0_0FFF);
    set_ins(7'b0110011, 3'b111, 7'b0000000); #1;
    chk("alu_and", u_if.alu_out, 32'h00F0_000F);
    set_ins(7'b0110011, 3'b010, 7'b0100000); #1;
    chk("alu_undef_mode", u_if.alu_out, 32'h0);

    // Comparator
    u_if.cmp_a = 32'hFFFF_FFFF; u_if.cmp_b = 32'h1;
    u_if.f3 = 3'b100; #1; chk("cmp_lt",   {31'd0, u_if.cmp_result}, 32'd1);
    u_if.f3 = 3'b110; #1; chk("cmp_ltu",  {31'd0, u_if.cmp_result}, 32'd0);
    u_if.f3 = 3'b101; #1; chk("cmp_ge",   {31'd0, u_if.cmp_result}, 32'd0);
    u_if.f3 = 3'b111; #1; chk("cmp_geu",  {31'd0, u_if.cmp_result}, 32'd1);
    u_if.cmp_a = 32'd5; u_if.cmp_b = 32'd5;
    u_if.f3 = 3'b000; #1; chk("cmp_eq",   {31'd0, u_if.cmp_result}, 32'd1);
    u_if.f3 = 3'b001; #1; chk("cmp_ne",   {31'd0, u_if.cmp_result}, 32'd0);
    u_if.f3 = 3'b010; #1; chk("cmp_f3_010", {31'd0, u_if.cmp_result}, 32'd0);

    // Decode of the other instruction classes
    set_ins(7'b0010011, 3'b000, 7'b0100000); #1;
    chk("addi_ctl", {24'd0, w_ctl}, 32'b0101_0000);
    chk("addi_mode_not_sub", {28'd0, u_if.alu_mode}, 32'b0000);
    set_ins(7'b0010011, 3'b101, 7'b0100000);
    u_if.alu_in_a = 32'h8000_0000; u_if.alu_in_b = 32'h4; #1;
    chk("srai_mode", {28'd0, u_if.alu_mode}, 32'b1101);
    chk("srai_result", u_if.alu_out, 32'hF800_0000);
    set_ins(7'b0100011, 3'b010, 7'b0000000); #1;
    chk("store_ctl", {24'd0, w_ctl}, 32'b0100_0001);
    set_ins(7'b1101111, 3'b000, 7'b0000000); #1;
    chk("jal_ctl", {24'd0, w_ctl}, 32'b1111_1000);
    set_ins(7'b1100111, 3'b000, 7'b0000000); #1;
    chk("jalr_ctl", {24'd0, w_ctl}, 32'b0111_1000);
    set_ins(7'b0110111, 3'b000, 7'b0000000);
    u_if.alu_in_a = 32'h1234_5678; u_if.alu_in_b = 32'hABCD_E000; #1;
    chk("lui_ctl", {24'd0, w_ctl}, 32'b0101_0000);
    chk("lui_pass_b", u_if.alu_out, 32'hABCD_E000);
    set_ins(7'b0010111, 3'b000, 7'b0000000); #1;
    chk("auipc_ctl", {24'd0, w_ctl}, 32'b1101_0000);
    set_ins(7'b1100011, 3'b000, 7'b0000000); #1;
    chk("branch_ctl", {24'd0, w_ctl}, 32'b0000_0100);
    set_ins(7'b0000011, 3'b010, 7'b0000000); #1;
    chk("load_ctl", {24'd0, w_ctl}, 32'b0110_0010);
    set_ins(7'b1110011, 3'b000, 7'b0000000); #1;
    chk("system_ctl", {24'd0, w_ctl}, 32'h0);
    set_ins(7'b1111111, 3'b111, 7'b1111111); #1;
    chk("unknown_ctl", {24'd0, w_ctl}, 32'h0);
    chk("unknown_mode", {28'd0, u_if.alu_mode}, 32'h0);
    chk("unknown_seq", {29'd0, w_seq}, 32'b001);

    // Asynchronous reset in the middle of an EXECUTE
    set_ins(7'b1101111, 3'b000, 7'b0000000);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("midreset_seq", {29'd0, w_seq}, 32'b110);
    chk("midreset_ctl", {24'd0, w_ctl}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    u_if.stall = 1'b0;
    #1;
    chk("post_reset_fetch", {29'd0, w_seq}, 32'b110);
    @(posedge clk);
    #1;
    chk("post_reset_exec_seq", {29'd0, w_seq}, 32'b001);
    chk("post_reset_jal_ctl", {24'd0, w_ctl}, 32'b1111_1000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
